// File: rtl/accel_log_pkg.sv
// Shared types and defaults for the accelerometer sample logger.
// Holds the FSM state encoding, default widths and a counter-width helper.
package accel_log_pkg;

  localparam int NBITS_DEF    = 7;
  localparam int NADDR_DEF    = 3;
  localparam int AVG_LOG2_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DUMP  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b = b + 1;
    return b;
  endfunction

endpackage

// File: rtl/block_averager.sv
// Sums incoming samples in blocks of 2**AVG_LOG2 and flags the completing
// sample together with the truncated block average.
module block_averager
  import accel_log_pkg::*;
#(
  parameter int NBits    = NBITS_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             smp_valid,
  input  logic [NBits-1:0] smp_data,
  output logic             done,
  output logic [NBits-1:0] avg
);

  localparam int CW = cnt_bits(1 << AVG_LOG2);
  localparam int AW = NBits + AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] smp_cnt;

  // The accumulator is wide enough for a full block, so the sum never wraps.
  assign sum  = acc + AW'(smp_data);
  assign done = smp_valid && (smp_cnt == LAST);
  assign avg  = sum[AW-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (smp_valid) begin
      if (done) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else begin
        acc     <= sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_sample_logger.sv
// Averages accelerometer samples into a ring-buffer RAM and dumps it oldest-first.
// Define LOGGER_OVERRUN_EN to add a sticky overrun flag for dropped averages.
module accel_sample_logger
  import accel_log_pkg::*;
#(
  parameter int NBits    = NBITS_DEF,
  parameter int NAddr    = NADDR_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             smp_valid,
  input  logic [NBits-1:0] smp_data,
  input  logic             dump_req,
  output logic [NAddr-1:0] ram_addr,
  output logic [NBits-1:0] ram_din,
  output logic             ram_wr_n,
  input  logic [NBits-1:0] ram_dout,
  output logic             rd_valid,
  output logic [NBits-1:0] rd_data,
  output logic [NAddr-1:0] rd_index,
  output logic             busy,
  output logic [NAddr:0]   count
`ifdef LOGGER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int DEPTH = 1 << NAddr;
  localparam logic [NAddr:0] FULL = (NAddr + 1)'(DEPTH);

  state_t           state, state_nxt;
  logic [NAddr-1:0] wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [NAddr:0]   count_nxt, dump_len, issued;
  logic [NBits-1:0] hold_data, blk_avg;
  logic             hold_v, blk_done;
  logic             write_now, dump_go, last_issue;

  block_averager #(
    .NBits   (NBits),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_a    (rst_a),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .done     (blk_done),
    .avg      (blk_avg)
  );

  assign write_now  = hold_v && (state == S_IDLE);
  assign wr_ptr_nxt = write_now ? wr_ptr + 1'b1 : wr_ptr;
  assign count_nxt  = (write_now && (count != FULL)) ? count + 1'b1 : count;
  assign dump_go    = (state == S_IDLE) && dump_req && (count != '0);
  assign last_issue = (state == S_DUMP) && (issued == dump_len - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dump_go) state_nxt = S_DUMP;
      S_DUMP:  if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A write issued alongside an accepted dump_req lands before the first read,
  // so the dump window is taken from the post-write pointer and count.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wr_ptr   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      dump_len <= '0;
      issued   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      if (dump_go) begin
        rd_ptr   <= wr_ptr_nxt - count_nxt[NAddr-1:0];
        dump_len <= count_nxt;
        issued   <= '0;
      end else if (state == S_DUMP) begin
        rd_ptr <= rd_ptr + 1'b1;
        issued <= issued + 1'b1;
      end
    end
  end

  // Completions that arrive while the hold slot is still occupied are dropped.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      hold_data <= '0;
      hold_v    <= 1'b0;
    end else if (blk_done && (!hold_v || write_now)) begin
      hold_data <= blk_avg;
      hold_v    <= 1'b1;
    end else if (write_now) begin
      hold_v <= 1'b0;
    end
  end

`ifdef LOGGER_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a)                                   overrun <= 1'b0;
    else if (blk_done && hold_v && !write_now)    overrun <= 1'b1;
    else if (dump_go)                             overrun <= 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      rd_valid <= 1'b0;
      rd_index <= '0;
    end else begin
      rd_valid <= (state == S_DUMP);
      rd_index <= issued[NAddr-1:0];
    end
  end

  assign rd_data  = rd_valid ? ram_dout : '0;
  assign busy     = (state != S_IDLE);
  assign ram_addr = (state == S_DUMP) ? rd_ptr : wr_ptr;
  assign ram_din  = hold_data;
  assign ram_wr_n = !write_now;

endmodule
